// File: rtl/garage_input_conditioner_if.sv
// Raw switch inputs and conditioned outputs between the
// garage input front end and its driver / the door FSM.
interface garage_input_conditioner_if;
  logic btn_raw;
  logic up_lim_raw;
  logic dn_lim_raw;
  logic Activate;
  logic UP_MAX;
  logic DN_MAX;
  logic lim_fault;

  modport master (
    output btn_raw,
    output up_lim_raw,
    output dn_lim_raw,
    input  Activate,
    input  UP_MAX,
    input  DN_MAX,
    input  lim_fault
  );

  modport slave (
    input  btn_raw,
    input  up_lim_raw,
    input  dn_lim_raw,
    output Activate,
    output UP_MAX,
    output DN_MAX,
    output lim_fault
  );
endinterface

// File: rtl/garage_input_conditioner.sv
// Garage door front end: sync + debounce of button and limits,
// one Activate pulse per press with lockout and fault suppression.
module garage_input_conditioner #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5,
  parameter int LOCKOUT   = 64,
  parameter int LK_W      = 7
) (
  input  logic clk,
  input  logic rst,
  garage_input_conditioner_if.slave io
);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [LK_W-1:0]  LK_LOAD = LK_W'(LOCKOUT - 1);

  logic [2:0] raw;
  logic [2:0] s1;
  logic [2:0] s2;
  logic [2:0] db;

  assign raw = {io.dn_lim_raw, io.up_lim_raw, io.btn_raw};

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Channel 0 = button, 1 = upper limit, 2 = lower limit.
  for (genvar c = 0; c < 3; c++) begin : g_db
    logic             q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (!rst) begin
        q   <= 1'b0;
        cnt <= '0;
      end else if (s2[c] == q) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        q   <= s2[c];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign db[c] = q;
  end

  logic            fault;
  logic            btn_prev;
  logic            fault_prev;
  logic            act;
  state_t          state;
  state_t          state_nx;
  logic [LK_W-1:0] lk_cnt;
  logic [LK_W-1:0] lk_nx;

  assign fault = db[1] & db[2];

  // fault_prev pairs with btn_prev, so a rise is judged against
  // the fault level from before the edge that raised btn_db.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lk_cnt     <= '0;
      btn_prev   <= 1'b0;
      fault_prev <= 1'b0;
      act        <= 1'b0;
    end else begin
      state      <= state_nx;
      lk_cnt     <= lk_nx;
      btn_prev   <= db[0];
      fault_prev <= fault;
      act        <= (state_nx == PULSE);
    end
  end

  always_comb begin
    state_nx = state;
    lk_nx    = lk_cnt;
    unique case (state)
      IDLE: begin
        if (db[0] && !btn_prev && !fault_prev)
          state_nx = PULSE;
      end
      PULSE: begin
        lk_nx    = LK_LOAD;
        state_nx = HOLD;
      end
      HOLD: begin
        if (lk_cnt != '0)
          lk_nx = lk_cnt - 1'b1;
        else if (!db[0])
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign io.Activate  = act;
  assign io.UP_MAX    = db[1];
  assign io.DN_MAX    = db[2];
  assign io.lim_fault = fault;

endmodule

// File: tb/tb_garage_input_conditioner.sv
// Bench for garage_input_conditioner: directed scenarios plus
// random stimulus against a history-based reference model.
module tb_garage_input_conditioner;

  localparam int DB = 4;
  localparam int LK = 8;
  localparam int ME = 4096;

  logic clk;
  logic rst;

  garage_input_conditioner_if io ();

  garage_input_conditioner #(
    .DB_CYCLES(DB),
    .CNT_W    (3),
    .LOCKOUT  (LK),
    .LK_W     (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model: histories indexed by edge number n.
  // sh = synchronised value after edge n, dbh = debounced level.
  bit rawh [3][ME];
  bit sh   [3][ME];
  bit dbh  [3][ME];
  bit fh   [ME];
  int n     = 0;
  int r     = 0;
  int p     = 0;
  bit busy  = 1'b0;
  bit armed = 1'b0;
  bit e_act, e_up, e_dn, e_f;

  always @(posedge clk) begin : model
    logic [2:0] rv;
    bit nd, all, rise, go;
    n++;
    if (n >= ME - 1) begin
      $display("FAIL model_depth: got %0d expected below %0d", n, ME);
      $fatal(1);
    end
    rv = {io.dn_lim_raw, io.up_lim_raw, io.btn_raw};
    if (!rst) begin
      r = n;
      for (int c = 0; c < 3; c++) begin
        rawh[c][n] = 1'b0;
        sh[c][n]   = 1'b0;
        dbh[c][n]  = 1'b0;
      end
      fh[n] = 1'b0;
      busy  = 1'b0;
      e_act = 1'b0;
      armed = 1'b1;
    end else begin
      for (int c = 0; c < 3; c++) begin
        rawh[c][n] = rv[c];
        sh[c][n]   = rawh[c][n-1];
        nd = dbh[c][n-1];
        // flip once DB post-reset samples all disagree with the level
        if (n - DB >= r && n > DB) begin
          all = 1'b1;
          for (int k = 1; k <= DB; k++)
            if (sh[c][n-k] == dbh[c][n-1]) all = 1'b0;
          if (all) nd = !nd;
        end
        dbh[c][n] = nd;
      end
      fh[n] = dbh[1][n] & dbh[2][n];
      rise = (n >= 2) && dbh[0][n-1] && !dbh[0][n-2] && !fh[n-2];
      go = !busy && rise;
      if (busy && n >= p + LK + 1 && !dbh[0][n-1]) busy = 1'b0;
      if (go) begin
        busy = 1'b1;
        p    = n;
      end
      e_act = go;
    end
    e_up = dbh[1][n];
    e_dn = dbh[2][n];
    e_f  = fh[n];
  end

  always @(negedge clk) begin
    if (armed)
      chk("outs",
          {28'd0, io.Activate, io.UP_MAX, io.DN_MAX, io.lim_fault},
          {28'd0, e_act, e_up, e_dn, e_f});
  end

  int ncyc    = 0;
  int last_at = -1;
  int min_gap = 100000;

  task automatic run(input int k, output int cnt, output int first);
    cnt   = 0;
    first = 0;
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      ncyc++;
      if (io.Activate === 1'b1) begin
        cnt++;
        if (first == 0) first = i;
        if (last_at >= 0 && ncyc - last_at < min_gap)
          min_gap = ncyc - last_at;
        last_at = ncyc;
      end
    end
  endtask

  initial begin : stim
    int c, f, c1, c2, c3, c4;
    rst           = 1'b0;
    io.btn_raw    = 1'b1;
    io.up_lim_raw = 1'b1;
    io.dn_lim_raw = 1'b1;

    // reset with all inputs high, then release
    run(3, c, f);
    chk("rst_outs",
        {io.Activate, io.UP_MAX, io.DN_MAX, io.lim_fault}, 4'b0000);
    rst = 1'b1;
    run(5, c, f);
    chk("s1_lim_e5", {io.UP_MAX, io.DN_MAX, io.lim_fault}, 3'b000);
    run(1, c, f);
    chk("s1_lim_e6", {io.UP_MAX, io.DN_MAX, io.lim_fault}, 3'b111);
    chk("s1_act_e6", io.Activate, 1'b0);
    run(1, c, f);
    chk("s1_act_e7", io.Activate, 1'b1);
    run(1, c, f);
    chk("s1_act_e8", io.Activate, 1'b0);
    io.btn_raw    = 1'b0;
    io.up_lim_raw = 1'b0;
    io.dn_lim_raw = 1'b0;
    run(40, c, f);

    // clean step and short glitch
    io.btn_raw = 1'b1;
    run(10, c, f);
    chk("s2_cnt", c, 1);
    chk("s2_at", f, 7);
    io.btn_raw = 1'b0;
    run(30, c, f);
    io.btn_raw = 1'b1;
    run(3, c1, f);
    io.btn_raw = 1'b0;
    run(30, c2, f);
    chk("s2_glitch", c1 + c2, 0);

    // re-press inside lockout, then a fresh press
    last_at = -1;
    min_gap = 100000;
    io.btn_raw = 1'b1;
    run(5, c1, f);
    io.btn_raw = 1'b0;
    run(4, c2, f);
    io.btn_raw = 1'b1;
    run(10, c3, f);
    io.btn_raw = 1'b0;
    run(30, c4, f);
    chk("s3_first", c1 + c2 + c3 + c4, 1);
    io.btn_raw = 1'b1;
    run(15, c, f);
    chk("s3_second", c, 1);
    io.btn_raw = 1'b0;
    run(30, c, f);
    chk("s3_gap_ok", min_gap >= LK + 1, 1'b1);

    // long hold, then release and press
    io.btn_raw = 1'b1;
    run(100, c, f);
    chk("s4_hold", c, 1);
    io.btn_raw = 1'b0;
    run(20, c, f);
    io.btn_raw = 1'b1;
    run(20, c, f);
    chk("s4_repress", c, 1);
    io.btn_raw = 1'b0;
    run(30, c, f);

    // limit fault suppresses presses
    io.up_lim_raw = 1'b1;
    io.dn_lim_raw = 1'b1;
    run(5, c, f);
    chk("s5_fault_e5", io.lim_fault, 1'b0);
    run(1, c, f);
    chk("s5_fault_e6", io.lim_fault, 1'b1);
    io.btn_raw = 1'b1;
    run(10, c, f);
    chk("s5_suppress", c, 0);
    io.btn_raw = 1'b0;
    run(15, c, f);
    io.dn_lim_raw = 1'b0;
    run(5, c, f);
    chk("s5_clear_e5", io.lim_fault, 1'b1);
    run(1, c, f);
    chk("s5_clear_e6", io.lim_fault, 1'b0);
    io.btn_raw = 1'b1;
    run(10, c, f);
    chk("s5_press", c, 1);
    io.btn_raw    = 1'b0;
    io.up_lim_raw = 1'b0;
    run(30, c, f);

    // reset during HOLD, then during a debounce count
    io.btn_raw = 1'b1;
    run(8, c, f);
    chk("s6_pulse", c, 1);
    io.btn_raw = 1'b0;
    run(2, c, f);
    rst = 1'b0;
    run(1, c, f);
    chk("s6_hold_rst",
        {io.Activate, io.UP_MAX, io.DN_MAX, io.lim_fault}, 4'b0000);
    rst = 1'b1;
    run(30, c, f);
    chk("s6_hold_quiet", c, 0);
    io.btn_raw = 1'b1;
    run(3, c, f);
    rst = 1'b0;
    io.btn_raw = 1'b0;
    run(1, c, f);
    chk("s6_db_rst",
        {io.Activate, io.UP_MAX, io.DN_MAX, io.lim_fault}, 4'b0000);
    rst = 1'b1;
    run(30, c, f);
    chk("s6_db_quiet", c, 0);

    // random stimulus, checked every cycle by the model
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b0;
        run(int'($urandom_range(1, 2)), c, f);
        rst = 1'b1;
      end
      io.btn_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) io.up_lim_raw = ~io.up_lim_raw;
      if ($urandom_range(0, 3) == 0) io.dn_lim_raw = ~io.dn_lim_raw;
      run(int'($urandom_range(1, 12)), c, f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
